// File: rtl/fifo_rd_stream.sv
// Drains a show-ahead FIFO into a valid/ready stream with burst framing.
// A 2-entry skid buffer keeps the FIFO pop strobe independent of the consumer's ready.
module fifo_rd_stream #(
  parameter int    DATA_WIDTH    = 8,
  parameter int    BURST_LEN     = 4,
  parameter string INSTANCE_NAME = "DEADF1F0",
  localparam int   CW            = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  output logic                  o_fifo_read,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last,
  output logic [CW-1:0]         o_beat_count,
  output logic [1:0]            o_occupancy
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  // Handshake: a beat transfers on a rising i_clk when o_m_valid && i_m_ready,
  // unless i_flush is high, in which case the transfer is discarded. o_m_valid
  // only falls after a transfer, a flush or reset.
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            occ;
  logic [CW-1:0]         beat;
  logic                  rd;
  logic                  hs;

  always_comb begin
    rd = !i_fifo_empty && (occ != 2'd2) && !i_flush;
    hs = (occ != 2'd0) && i_m_ready && !i_flush;
  end

  assign o_fifo_read  = rd;
  assign o_m_valid    = (occ != 2'd0);
  assign o_m_data     = mem[head];
  assign o_m_last     = o_m_valid && (beat == LAST_BEAT);
  assign o_beat_count = beat;
  assign o_occupancy  = occ;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      occ    <= 2'd0;
      beat   <= '0;
    end else if (i_flush) begin
      // Data registers keep stale contents; occupancy alone marks them empty.
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
      beat <= '0;
    end else begin
      if (rd) begin
        mem[tail] <= i_fifo_rd_data;
        tail      <= ~tail;
      end
      if (hs) begin
        head <= ~head;
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
      case ({rd, hs})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic hold_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_valid <= 1'b0;
    end else begin
      if (rd && i_fifo_empty)
        $error("%s: FIFO popped while empty at time %0t", INSTANCE_NAME, $time);
      if (hold_valid && !o_m_valid)
        $error("%s: stream valid dropped without handshake at time %0t", INSTANCE_NAME, $time);
      hold_valid <= o_m_valid && !hs && !i_flush;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model feeding the DUT, a table of per-cycle vectors,
// and a scoreboard of popped words checked against stream handshakes.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_flush;
  logic          o_fifo_read;
  logic          i_fifo_empty;
  logic [DW-1:0] i_fifo_rd_data;
  logic          o_m_valid;
  logic          i_m_ready;
  logic [DW-1:0] o_m_data;
  logic          o_m_last;
  logic [1:0]    o_beat_count;
  logic [1:0]    o_occupancy;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL), .INSTANCE_NAME("TB_DUT")) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .o_fifo_read(o_fifo_read), .i_fifo_empty(i_fifo_empty), .i_fifo_rd_data(i_fifo_rd_data),
    .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data),
    .o_m_last(o_m_last), .o_beat_count(o_beat_count), .o_occupancy(o_occupancy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int            push_n;
    logic [DW-1:0] push_base;
    logic          ready;
    logic          flush;
    logic          exp_read;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_last;
    logic [1:0]    exp_occ;
    logic [1:0]    exp_beat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];
  vec_t none;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int exp_beat   = 0;
  int hs_total   = 0;
  int last_total = 0;
  bit last_valid = 0;
  int n_vec  = 0;
  int n_miss = 0;
  int span   = 0;
  int lasts  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int pn, logic [DW-1:0] pb, logic rdy, logic fl, logic er,
                              logic ev, logic [DW-1:0] ed, logic el, logic [1:0] eo, logic [1:0] eb);
    vec_t v;
    v.push_n = pn; v.push_base = pb; v.ready = rdy; v.flush = fl; v.exp_read = er;
    v.exp_valid = ev; v.exp_data = ed; v.exp_last = el; v.exp_occ = eo; v.exp_beat = eb;
    return v;
  endfunction

  task automatic drive_fifo();
    i_fifo_empty   = (fifo_q.size() == 0);
    i_fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) fifo_q.push_back(base + k[DW-1:0]);
    drive_fifo();
  endtask

  // Samples at the falling edge with inputs already settled, then advances one cycle.
  task automatic tick(input bit chk, input vec_t v);
    bit hs, rd;
    logic [DW-1:0] e;
    @(negedge i_clk);
    if (chk) begin
      check("vec_read",  o_fifo_read,  v.exp_read);
      check("vec_valid", o_m_valid,    v.exp_valid);
      check("vec_data",  o_m_data,     v.exp_data);
      check("vec_last",  o_m_last,     v.exp_last);
      check("vec_occ",   o_occupancy,  v.exp_occ);
      check("vec_beat",  o_beat_count, v.exp_beat);
    end
    check("occ_model",  o_occupancy,  exp_q.size());
    check("beat_model", o_beat_count, exp_beat);
    if (o_fifo_read)      check("read_nonempty", i_fifo_empty, 0);
    if (i_flush)          check("read_on_flush", o_fifo_read, 0);
    if (o_occupancy == 2) check("read_when_full", o_fifo_read, 0);
    hs = o_m_valid && i_m_ready && !i_flush;
    rd = o_fifo_read && (fifo_q.size() != 0);
    last_valid = o_m_valid;
    if (hs) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_data", o_m_data, e);
        check("sb_last", o_m_last, exp_beat == BL - 1);
      end
      exp_beat = (exp_beat == BL - 1) ? 0 : exp_beat + 1;
      hs_total++;
      if (o_m_last) last_total++;
    end
    if (rd) exp_q.push_back(fifo_q[0]);
    @(posedge i_clk);
    #1;
    if (rd) void'(fifo_q.pop_front());
    if (i_flush) begin
      exp_q.delete();
      exp_beat = 0;
    end
    drive_fifo();
  endtask

  // Runs until target handshakes or budget cycles; span counts cycles from first valid.
  task automatic run_hs(input string name, input int target, input bit alt, input int budget);
    int start = hs_total;
    int lstart = last_total;
    int cyc = 0;
    bit seen = 0;
    span = 0;
    while ((hs_total - start) < target && cyc < budget) begin
      i_m_ready = alt ? (cyc % 2 == 0) : 1'b1;
      tick(0, none);
      if (last_valid) seen = 1;
      if (seen) span++;
      cyc++;
    end
    lasts = last_total - lstart;
    check(name, hs_total - start, target);
  endtask

  initial begin
    vecs[0]  = mk(1, 8'hA5, 1, 0, 1, 0, 8'h00, 0, 0, 0);
    vecs[1]  = mk(0, 8'h00, 1, 0, 0, 1, 8'hA5, 0, 1, 0);
    vecs[2]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 1);
    vecs[3]  = mk(4, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1);
    vecs[4]  = mk(0, 8'h00, 0, 0, 1, 1, 8'h00, 0, 1, 1);
    vecs[5]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 2, 1);
    vecs[6]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 2, 1);
    vecs[7]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 2, 1);
    vecs[8]  = mk(0, 8'h00, 1, 0, 0, 1, 8'h00, 0, 2, 1);
    vecs[9]  = mk(0, 8'h00, 1, 0, 1, 1, 8'h01, 0, 1, 2);
    vecs[10] = mk(0, 8'h00, 1, 0, 1, 1, 8'h02, 1, 1, 3);
    vecs[11] = mk(0, 8'h00, 1, 0, 0, 1, 8'h03, 0, 1, 0);
    vecs[12] = mk(0, 8'h00, 1, 0, 0, 0, 8'h02, 0, 0, 1);
    vecs[13] = mk(1, 8'h10, 0, 0, 1, 0, 8'h02, 0, 0, 1);
    vecs[14] = mk(0, 8'h00, 1, 0, 0, 1, 8'h10, 0, 1, 1);
    vecs[15] = mk(3, 8'h20, 0, 0, 1, 0, 8'h03, 0, 0, 2);
    vecs[16] = mk(0, 8'h00, 0, 0, 1, 1, 8'h20, 0, 1, 2);
    vecs[17] = mk(0, 8'h00, 0, 0, 0, 1, 8'h20, 0, 2, 2);
    vecs[18] = mk(0, 8'h00, 1, 1, 0, 1, 8'h20, 0, 2, 2);
    vecs[19] = mk(0, 8'h00, 0, 0, 1, 0, 8'h20, 0, 0, 0);
    vecs[20] = mk(0, 8'h00, 1, 0, 0, 1, 8'h22, 0, 1, 0);
    vecs[21] = mk(0, 8'h00, 1, 0, 0, 0, 8'h21, 0, 0, 1);
    none = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);

    // Clock/reset
    i_rst_n = 1'b0; i_flush = 1'b0; i_m_ready = 1'b0;
    drive_fifo();
    #12;
    check("rst_valid", o_m_valid, 0);
    check("rst_data",  o_m_data, 0);
    check("rst_last",  o_m_last, 0);
    check("rst_beat",  o_beat_count, 0);
    check("rst_occ",   o_occupancy, 0);
    check("rst_read",  o_fifo_read, 0);
    #4 i_rst_n = 1'b1;

    // Single word, backpressure and flush, cycle by cycle
    for (int i = 0; i < NV; i++) begin
      push_words(vecs[i].push_n, vecs[i].push_base);
      i_m_ready = vecs[i].ready;
      i_flush   = vecs[i].flush;
      tick(1, vecs[i]);
    end
    i_flush = 1'b0;

    // Streaming: clear the beat counter, then 8 back-to-back beats
    i_flush = 1'b1; i_m_ready = 1'b0;
    tick(0, none);
    i_flush = 1'b0;
    push_words(8, 8'h00);
    run_hs("stream_count", 8, 0, 40);
    check("stream_span", span, 8);
    check("stream_lasts", lasts, 2);

    // Alternating ready
    push_words(6, 8'h40);
    run_hs("alt_count", 6, 1, 60);
    i_m_ready = 1'b0;
    tick(0, none);

    // Asynchronous reset with one entry held
    push_words(1, 8'h50);
    tick(0, none);
    check("pre_rst_occ", o_occupancy, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid", o_m_valid, 0);
    check("arst_data",  o_m_data, 0);
    check("arst_last",  o_m_last, 0);
    check("arst_beat",  o_beat_count, 0);
    check("arst_occ",   o_occupancy, 0);
    check("arst_read",  o_fifo_read, 0);
    fifo_q.delete();
    exp_q.delete();
    exp_beat = 0;
    drive_fifo();
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    push_words(4, 8'h30);
    run_hs("post_rst_count", 4, 0, 30);
    check("post_rst_lasts", lasts, 1);
    i_m_ready = 1'b0;
    tick(0, none);
    check("post_rst_idle", o_m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
